// File: rtl/ocr_best_match.sv
// Best/second-best score tracker for one OCR frame of N_TEMPLATES correlation scores.
// Reports winner index, score, confidence margin and reject flag with a valid/ack handshake.
module ocr_best_match #(
    parameter int unsigned        N_TEMPLATES = 36,
    parameter int unsigned        SCORE_W     = 32,
    parameter int unsigned        IDX_W       = 8,
    parameter logic [SCORE_W-1:0] MIN_SCORE   = '0
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               START,
    input  logic [SCORE_W-1:0] SCORE_IN,
    input  logic [IDX_W-1:0]   SCORE_IDX,
    input  logic               SCORE_VLD,
    output logic               SCORE_RDY,
    input  logic               RESULT_ACK,
    output logic [IDX_W-1:0]   BEST_IDX,
    output logic [SCORE_W-1:0] BEST_SCORE,
    output logic [SCORE_W-1:0] MARGIN,
    output logic               REJECT,
    output logic               RESULT_VLD,
    output logic               SEQ_ERR,
    output logic               BUSY
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_REPORT
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_TEMPLATES - 1);

    state_t             state;
    state_t             state_n;
    logic               start_frame;
    logic               accept;
    logic [IDX_W-1:0]   count;
    logic [SCORE_W-1:0] second;
    logic [SCORE_W-1:0] best_n;
    logic [SCORE_W-1:0] second_n;
    logic [IDX_W-1:0]   idx_n;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // A START that restarts the frame wins over a score presented in the same cycle.
    always_comb begin
        state_n     = state;
        start_frame = 1'b0;
        accept      = 1'b0;
        SCORE_RDY   = 1'b0;
        RESULT_VLD  = 1'b0;
        BUSY        = 1'b1;
        case (state)
            S_IDLE: begin
                BUSY = 1'b0;
                if (START) begin
                    start_frame = 1'b1;
                    state_n     = S_COLLECT;
                end
            end
            S_COLLECT: begin
                SCORE_RDY = 1'b1;
                if (START) begin
                    start_frame = 1'b1;
                end else if (SCORE_VLD) begin
                    accept = 1'b1;
                    if (count == LAST_IDX) begin
                        state_n = S_REPORT;
                    end
                end
            end
            S_REPORT: begin
                RESULT_VLD = 1'b1;
                if (RESULT_ACK) begin
                    if (START) begin
                        start_frame = 1'b1;
                        state_n     = S_COLLECT;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
                BUSY    = 1'b0;
            end
        endcase
    end

    always_comb begin
        best_n   = BEST_SCORE;
        second_n = second;
        idx_n    = BEST_IDX;
        if (SCORE_IN > BEST_SCORE) begin
            second_n = BEST_SCORE;
            best_n   = SCORE_IN;
            idx_n    = SCORE_IDX;
        end else if (SCORE_IN > second) begin
            second_n = SCORE_IN;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            BEST_SCORE <= '0;
            second     <= '0;
            BEST_IDX   <= '0;
            count      <= '0;
            SEQ_ERR    <= 1'b0;
            MARGIN     <= '0;
            REJECT     <= 1'b0;
        end else if (start_frame) begin
            BEST_SCORE <= '0;
            second     <= '0;
            BEST_IDX   <= '0;
            count      <= '0;
            SEQ_ERR    <= 1'b0;
            MARGIN     <= '0;
            REJECT     <= 1'b0;
        end else if (accept) begin
            BEST_SCORE <= best_n;
            second     <= second_n;
            BEST_IDX   <= idx_n;
            count      <= count + 1'b1;
            if (SCORE_IDX != count) begin
                SEQ_ERR <= 1'b1;
            end
            if (count == LAST_IDX) begin
                MARGIN <= best_n - second_n;
                REJECT <= (best_n < MIN_SCORE);
            end
        end
    end

endmodule
